// File: rtl/cmp_arb.sv
// Two-port round-robin arbiter in front of one shared 32-bit comparator.
// Each granted request is evaluated in a single cycle and registered into that requester's own response slot.
module cmp_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_r1,
  input  logic [31:0]      req0_r2,
  input  logic [2:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp0_result,
  output logic             rsp0_illegal,
  output logic [TAG_W-1:0] rsp0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_r1,
  input  logic [31:0]      req1_r2,
  input  logic [2:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic             rsp1_result,
  output logic             rsp1_illegal,
  output logic [TAG_W-1:0] rsp1_tag
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // reqN_ready depends only on the valids, rspN_ready, the slot state and rst_n, never on operands.

  logic             last_gnt;
  logic             free0, free1;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic [31:0]      sel_r1, sel_r2;
  logic [2:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic             cmp_eq, cmp_lt_s, cmp_lt_u;
  logic             cmp_base, cmp_result, cmp_illegal;

  always_comb begin
    free0  = !rsp0_valid || rsp0_ready;
    free1  = !rsp1_valid || rsp1_ready;
    elig0  = rst_n && req0_valid && free0;
    elig1  = rst_n && req1_valid && free1;
    // On contention the requester not granted last time wins.
    grant0 = elig0 && (!elig1 || last_gnt);
    grant1 = elig1 && (!elig0 || !last_gnt);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    sel_r1  = grant1 ? req1_r1  : req0_r1;
    sel_r2  = grant1 ? req1_r2  : req0_r2;
    sel_op  = grant1 ? req1_op  : req0_op;
    sel_tag = grant1 ? req1_tag : req0_tag;
  end

  always_comb begin
    cmp_eq   = (sel_r1 == sel_r2);
    cmp_lt_s = ($signed(sel_r1) < $signed(sel_r2));
    cmp_lt_u = (sel_r1 < sel_r2);
    case (sel_op[2:1])
      2'b00:   cmp_base = cmp_eq;
      2'b10:   cmp_base = cmp_lt_s;
      2'b11:   cmp_base = cmp_lt_u;
      default: cmp_base = 1'b0;
    endcase
    cmp_result  = cmp_base ^ sel_op[0];
    cmp_illegal = (sel_op[2:1] == 2'b01);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt     <= 1'b1;
      rsp0_valid   <= 1'b0;
      rsp0_result  <= 1'b0;
      rsp0_illegal <= 1'b0;
      rsp0_tag     <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_result  <= 1'b0;
      rsp1_illegal <= 1'b0;
      rsp1_tag     <= '0;
    end else begin
      if (grant0 || grant1) begin
        last_gnt <= grant1;
      end
      // A refill takes priority over a drain so the slot never bubbles.
      if (grant0) begin
        rsp0_valid   <= 1'b1;
        rsp0_result  <= cmp_result;
        rsp0_illegal <= cmp_illegal;
        rsp0_tag     <= sel_tag;
      end else if (rsp0_ready) begin
        rsp0_valid   <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid   <= 1'b1;
        rsp1_result  <= cmp_result;
        rsp1_illegal <= cmp_illegal;
        rsp1_tag     <= sel_tag;
      end else if (rsp1_ready) begin
        rsp1_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmp_arb.sv
// Bench for cmp_arb: directed test-plan scenarios plus random traffic, all checked
// against a queue-based reference model of the two response slots.
module tb_cmp_arb;
  localparam int TAG_W = 4;
  localparam int EW = TAG_W + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_r1, req0_r2, req1_r1, req1_r2;
  logic [2:0]       req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic             rsp0_result, rsp1_result;
  logic             rsp0_illegal, rsp1_illegal;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;

  int n_cmp = 0;
  int n_err = 0;

  // Expected responses, entry = {result, illegal, tag}; each slot holds at most one.
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int            m_last = 1;
  logic          exp_rdy0, exp_rdy1;

  always #5 clk = ~clk;

  cmp_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r1(req0_r1), .req0_r2(req0_r2),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_illegal(rsp0_illegal), .rsp0_tag(rsp0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r1(req1_r1), .req1_r2(req1_r2),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_illegal(rsp1_illegal), .rsp1_tag(rsp1_tag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      3'd2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [EW-1:0] ref_entry(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [TAG_W-1:0] t);
    return {ref_cmp(op, a, b), (op == 3'd2 || op == 3'd3), t};
  endfunction

  task automatic drive_idle();
    req0_valid = 0; req1_valid = 0;
    req0_r1 = 0; req0_r2 = 0; req0_op = 0; req0_tag = 0;
    req1_r1 = 0; req1_r2 = 0; req1_op = 0; req1_tag = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [TAG_W-1:0] t);
    req0_valid = 1; req0_r1 = a; req0_r2 = b; req0_op = op; req0_tag = t;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [TAG_W-1:0] t);
    req1_valid = 1; req1_r1 = a; req1_r2 = b; req1_op = op; req1_tag = t;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step(input bit chk);
    bit free0, free1, e0, e1;
    #1;
    free0 = (exp_q0.size() == 0) || rsp0_ready;
    free1 = (exp_q1.size() == 0) || rsp1_ready;
    e0 = rst_n && req0_valid && free0;
    e1 = rst_n && req1_valid && free1;
    exp_rdy0 = e0 && !(e1 && m_last == 0);
    exp_rdy1 = e1 && !(e0 && m_last == 1);
    if (chk) begin
      check("req0_ready", req0_ready, exp_rdy0);
      check("req1_ready", req1_ready, exp_rdy1);
      check("rsp0_valid", rsp0_valid, exp_q0.size() != 0);
      check("rsp1_valid", rsp1_valid, exp_q1.size() != 0);
      if (exp_q0.size() != 0) check("rsp0_data", {rsp0_result, rsp0_illegal, rsp0_tag}, exp_q0[0]);
      if (exp_q1.size() != 0) check("rsp1_data", {rsp1_result, rsp1_illegal, rsp1_tag}, exp_q1[0]);
    end
    @(posedge clk);
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      m_last = 1;
    end else begin
      if (rsp0_ready && exp_q0.size() != 0) void'(exp_q0.pop_front());
      if (rsp1_ready && exp_q1.size() != 0) void'(exp_q1.pop_front());
      if (exp_rdy0) begin
        exp_q0.push_back(ref_entry(req0_op, req0_r1, req0_r2, req0_tag));
        m_last = 0;
      end
      if (exp_rdy1) begin
        exp_q1.push_back(ref_entry(req1_op, req1_r1, req1_r2, req1_tag));
        m_last = 1;
      end
    end
    @(negedge clk);
  endtask

  logic [2:0] dir_op[6]  = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic       dir_exp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    drive_idle();
    rst_n = 0;
    step(0);
    step(1);
    rst_n = 1;
    step(1);

    // Signed/unsigned and equality ops on port 0, result one cycle after accept.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive0(32'hFFFF_FFFF, 32'h0000_0001, dir_op[i], 4'(i));
      else       drive0(32'h1234, 32'h1234, dir_op[i], 4'(i));
      step(1);
      check("dir_result", rsp0_result, dir_exp[i]);
    end
    // Illegal ops echo tag 0xA.
    drive0(32'h5, 32'h5, 3'd2, 4'hA);
    step(1);
    check("ill010", {rsp0_result, rsp0_illegal, rsp0_tag}, {1'b0, 1'b1, 4'hA});
    drive0(32'h5, 32'h7, 3'd3, 4'hA);
    step(1);
    check("ill011", {rsp0_result, rsp0_illegal, rsp0_tag}, {1'b1, 1'b1, 4'hA});
    drive_idle();
    step(1);

    // Contention right after reset: 0 first, then alternating.
    rst_n = 0;
    step(1);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      drive0($urandom, $urandom, 3'd0, 4'(i));
      drive1($urandom, $urandom, 3'd1, 4'(i + 8));
      step(1);
      check("cont_gnt0", rsp0_valid && rsp0_tag == 4'(i), (i % 2) == 0);
    end

    // Backpressure on port 1 for 3 cycles after its accept.
    drive_idle();
    step(1);
    drive1(32'h10, 32'h20, 3'd6, 4'h7);
    step(1);
    rsp1_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive0($urandom, $urandom, 3'($urandom_range(0, 7)), 4'(i));
      drive1(32'h30, 32'h30, 3'd0, 4'h9);
      step(1);
      check("bp_hold", {rsp1_valid, rsp1_result, rsp1_tag}, {1'b1, 1'b1, 4'h7});
    end
    rsp1_ready = 1;
    step(1);
    check("bp_refill", {rsp1_valid, rsp1_result, rsp1_tag}, {1'b1, 1'b1, 4'h9});

    // Reset while a response is stalled.
    drive_idle();
    rsp0_ready = 0;
    drive0(32'h1, 32'h2, 3'd4, 4'h3);
    step(1);
    rst_n = 0;
    step(1);
    check("rst_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    rst_n = 1;
    rsp0_ready = 1;
    drive0(32'h1, 32'h1, 3'd0, 4'h1);
    drive1(32'h1, 32'h1, 3'd0, 4'h2);
    step(1);
    check("rst_first", {rsp0_valid, rsp1_valid}, 2'b10);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      req0_valid = $urandom_range(0, 3) != 0;
      req1_valid = $urandom_range(0, 3) != 0;
      req0_r1 = a;
      req0_r2 = ($urandom_range(0, 3) == 0) ? a : $urandom;
      req1_r1 = $urandom;
      req1_r2 = ($urandom_range(0, 3) == 0) ? req1_r1 : $urandom;
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_tag = 4'($urandom);
      req1_tag = 4'($urandom);
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      step(1);
    end
    rst_n = 1;
    drive_idle();
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
